timer_rearm_ctrl: RTL and testbench
===================================

// Module: timer_rearm_ctrl
// PURPOSE
//  Downstream controller for the terminal-count timer stage. It consumes that stage's
//  registered "count reached" level (done_in) and detects its rising edge. On each event
//  it raises a held interrupt, counts the event, and drives a restart pulse that
//  re-arms the upstream timer.
//  It sits between the timer and the host/event logic; all signals are in one clock domain.
// PARAMETERS
//  CNT_W       8   width of the event counter evt_count
//  RST_LEN     2   restart pulse length in clk cycles; legal range 1..15
//  AUTO_REARM  1   1: re-arm right after an event; 0: wait for ack before re-arming
// PORTS
//  clk        in   1      system clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  enable     in   1      1 = controller running; 0 = go to IDLE
//  done_in    in   1      level from the upstream timer; high once terminal count is reached
//  ack        in   1      host acknowledge; clears irq; releases HOLD
//  clr_cnt    in   1      synchronous clear of evt_count and ovf
//  restart    out  1      restart pulse to the upstream timer reset, active high
//  irq        out  1      event-pending flag; held until ack
//  evt_count  out  CNT_W  number of events seen; saturates at all-ones
//  ovf        out  1      sticky flag: an event arrived while evt_count was saturated
//  busy       out  1      1 whenever state != IDLE
// BEHAVIOUR
//  Reset (rst_n=0, async)
//   - state=IDLE; restart=0, irq=0, evt_count=0, ovf=0, done_d=0, rst_cnt=0.
//  Edge detect
//   - done_d is a register of done_in, updated every cycle.
//   - rise = done_in & ~done_d. rise is used only in ARMED.
//  All outputs are registered. State and rst_cnt are 4-bit registers.
//  FSM transitions, one per clk edge:
//   - IDLE: enable=1 -> RESTART, with rst_cnt=RST_LEN. The timer is always cleared before arming.
//   - RESTART: restart=1 while in this state.
//     rst_cnt decrements each cycle; when rst_cnt==1 -> ARMED.
//     The restart pulse is exactly RST_LEN cycles wide.
//   - ARMED: rise -> FIRED. On that same edge: irq<=1 and evt_count<=evt_count+1 (saturating).
//     If evt_count is already all-ones, evt_count holds and ovf<=1.
//   - FIRED, 1 cycle: AUTO_REARM=1 -> RESTART; AUTO_REARM=0 -> HOLD.
//   - HOLD: ack=1 -> RESTART. done_in is ignored in HOLD.
//   - Any state: enable=0 -> IDLE on the next edge.
//     restart<=0 on that edge; irq, evt_count and ovf are kept.
//  Latency
//   - done_in first seen high at edge N -> irq and evt_count update at edge N+1.
//   - restart rises at edge N+2 and stays high for RST_LEN cycles.
//   - Minimum re-arm interval is RST_LEN+2 cycles.
//  irq handling
//   - ack=1 clears irq, in any state.
//   - If ack and a new event land on the same edge, the set wins: irq=1.
//  clr_cnt
//   - clr_cnt=1 -> evt_count<=0 and ovf<=0.
//   - If clr_cnt and an event land on the same edge: evt_count<=1, ovf<=0.
//  done_in stuck high
//   - A level held across RESTART/ARMED without a new 0->1 transition is not an event.
//   - A fresh rise is required.
//  Reset mid-operation
//   - rst_n low in any state forces the reset values immediately. restart drops asynchronously.
//  Illegal state encodings -> IDLE.
// TESTING
//  1. Reset: rst_n=0 mid-RESTART -> restart, irq, evt_count, ovf, busy all 0 immediately.
//  2. AUTO_REARM=1, RST_LEN=2, enable=1, done_in pulses high 3 times 10 cycles apart
//     -> evt_count=3, irq=1 after first event, restart is 2 cycles high 2 cycles after each rise.
//  3. AUTO_REARM=0: event, then ack after 20 cycles -> state stays HOLD, restart=0 until ack;
//     restart 1 cycle after ack; irq=0.
//  4. CNT_W=2: 5 events -> evt_count=3 and ovf=1; clr_cnt=1 -> evt_count=0, ovf=0.
//  5. ack and done_in rise on the same edge in ARMED with irq=1 -> irq stays 1, count+1.
//  6. done_in held high for 50 cycles through RESTART -> exactly 1 event counted;
//     enable=0 -> IDLE next cycle, busy=0, evt_count kept.

Source files
------------

// File: rtl/timer_rearm_ctrl_if.sv
// Signal bundle between the terminal-count timer / host logic and timer_rearm_ctrl.
// master = timer and host side, slave = the controller.
interface timer_rearm_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             enable;
  logic             done_in;
  logic             ack;
  logic             clr_cnt;
  logic             restart;
  logic             irq;
  logic [CNT_W-1:0] evt_count;
  logic             ovf;
  logic             busy;

  modport master (
    output enable, done_in, ack, clr_cnt,
    input  restart, irq, evt_count, ovf, busy
  );

  modport slave (
    input  enable, done_in, ack, clr_cnt,
    output restart, irq, evt_count, ovf, busy
  );
endinterface

// File: rtl/timer_rearm_ctrl.sv
// Detects terminal-count events from the upstream timer, raises a held irq,
// counts events and drives the restart pulse that re-arms the timer.
//
// state   | meaning
// IDLE    | controller disabled, timer left alone
// RESTART | restart pulse high, rst_cnt counting down the pulse length
// ARMED   | waiting for a fresh 0->1 transition on done_in
// FIRED   | one-cycle event stage after a detected rise
// HOLD    | waiting for host ack before re-arming (AUTO_REARM=0 only)
module timer_rearm_ctrl #(
  parameter int CNT_W      = 8,
  parameter int RST_LEN    = 2,
  parameter int AUTO_REARM = 1
) (
  input logic               clk,
  input logic               rst_n,
  timer_rearm_ctrl_if.slave bus
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_RESTART = 4'd1;
  localparam logic [3:0] S_ARMED   = 4'd2;
  localparam logic [3:0] S_FIRED   = 4'd3;
  localparam logic [3:0] S_HOLD    = 4'd4;

  localparam logic [3:0] RST_LEN_C = 4'(RST_LEN);

  logic [3:0]       state_q, state_d;
  logic [3:0]       rst_cnt_q, rst_cnt_d;
  logic             done_d;
  logic             rise;
  logic             evt;

  logic             restart_q, restart_d;
  logic             irq_q, irq_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;

  assign rise = bus.done_in & ~done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rst_cnt_q <= 4'd0;
      done_d    <= 1'b0;
      restart_q <= 1'b0;
      irq_q     <= 1'b0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      done_d    <= bus.done_in;
      restart_q <= restart_d;
      irq_q     <= irq_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
    end
  end

  // Dropping enable wins over every transition, including a rise seen in ARMED.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    if (!bus.enable) begin
      state_d   = S_IDLE;
      rst_cnt_d = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d   = S_RESTART;
          rst_cnt_d = RST_LEN_C;
        end
        S_RESTART: begin
          if (rst_cnt_q <= 4'd1) begin
            state_d   = S_ARMED;
            rst_cnt_d = 4'd0;
          end else begin
            rst_cnt_d = rst_cnt_q - 4'd1;
          end
        end
        S_ARMED: begin
          if (rise) state_d = S_FIRED;
        end
        S_FIRED: begin
          if (AUTO_REARM != 0) begin
            state_d   = S_RESTART;
            rst_cnt_d = RST_LEN_C;
          end else begin
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.ack) begin
            state_d   = S_RESTART;
            rst_cnt_d = RST_LEN_C;
          end
        end
        default: begin
          state_d   = S_IDLE;
          rst_cnt_d = 4'd0;
        end
      endcase
    end
  end

  // Event bookkeeping: a new event beats a same-cycle ack or clear.
  always_comb begin
    evt       = bus.enable && (state_q == S_ARMED) && rise;
    restart_d = (state_d == S_RESTART);
    busy_d    = (state_d != S_IDLE);

    irq_d = irq_q;
    if (bus.ack) irq_d = 1'b0;
    if (evt)     irq_d = 1'b1;

    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (evt) begin
      if (bus.clr_cnt) begin
        cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
        ovf_d = 1'b0;
      end else if (&cnt_q) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (bus.clr_cnt) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end
  end

  assign bus.restart   = restart_q;
  assign bus.irq       = irq_q;
  assign bus.evt_count = cnt_q;
  assign bus.ovf       = ovf_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_timer_rearm_ctrl.sv
// Directed bench for timer_rearm_ctrl: three configurations share clock and reset,
// inputs change on the falling edge and outputs are sampled on the falling edge.
module tb_timer_rearm_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  timer_rearm_ctrl_if #(.CNT_W(8)) a_if ();
  timer_rearm_ctrl_if #(.CNT_W(8)) b_if ();
  timer_rearm_ctrl_if #(.CNT_W(2)) c_if ();

  timer_rearm_ctrl #(.CNT_W(8), .RST_LEN(2), .AUTO_REARM(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  timer_rearm_ctrl #(.CNT_W(8), .RST_LEN(2), .AUTO_REARM(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if.slave));
  timer_rearm_ctrl #(.CNT_W(2), .RST_LEN(1), .AUTO_REARM(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(c_if.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle done_in pulse on dut_a, then the re-arm sequence; 10 cycles in total.
  task automatic a_event(input int exp_cnt);
    a_if.done_in = 1'b1;
    @(negedge clk);
    check("a_evt_irq", 32'(a_if.irq), 32'd1);
    check("a_evt_cnt", 32'(a_if.evt_count), 32'(exp_cnt));
    check("a_evt_restart_fired", 32'(a_if.restart), 32'd0);
    a_if.done_in = 1'b0;
    @(negedge clk);
    check("a_evt_restart_1", 32'(a_if.restart), 32'd1);
    @(negedge clk);
    check("a_evt_restart_2", 32'(a_if.restart), 32'd1);
    @(negedge clk);
    check("a_evt_restart_end", 32'(a_if.restart), 32'd0);
    check("a_evt_busy", 32'(a_if.busy), 32'd1);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    a_if.enable = 1'b0; a_if.done_in = 1'b0; a_if.ack = 1'b0; a_if.clr_cnt = 1'b0;
    b_if.enable = 1'b0; b_if.done_in = 1'b0; b_if.ack = 1'b0; b_if.clr_cnt = 1'b0;
    c_if.enable = 1'b0; c_if.done_in = 1'b0; c_if.ack = 1'b0; c_if.clr_cnt = 1'b0;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_restart", 32'(a_if.restart), 32'd0);
    check("rst_irq", 32'(a_if.irq), 32'd0);
    check("rst_cnt", 32'(a_if.evt_count), 32'd0);
    check("rst_ovf", 32'(a_if.ovf), 32'd0);
    check("rst_busy", 32'(a_if.busy), 32'd0);

    // auto re-arm, RST_LEN=2
    a_if.enable = 1'b1;
    @(negedge clk);
    check("a_arm_restart_1", 32'(a_if.restart), 32'd1);
    check("a_arm_busy", 32'(a_if.busy), 32'd1);
    @(negedge clk);
    check("a_arm_restart_2", 32'(a_if.restart), 32'd1);
    @(negedge clk);
    check("a_arm_restart_end", 32'(a_if.restart), 32'd0);
    a_event(1);
    a_event(2);
    a_event(3);
    check("a_three_cnt", 32'(a_if.evt_count), 32'd3);

    // ack and rise on the same edge: set wins
    a_if.ack = 1'b1;
    a_if.done_in = 1'b1;
    @(negedge clk);
    check("a_ack_rise_irq", 32'(a_if.irq), 32'd1);
    check("a_ack_rise_cnt", 32'(a_if.evt_count), 32'd4);
    a_if.ack = 1'b0;
    a_if.done_in = 1'b0;
    repeat (3) @(negedge clk);
    a_if.ack = 1'b1;
    @(negedge clk);
    check("a_ack_clear_irq", 32'(a_if.irq), 32'd0);
    a_if.ack = 1'b0;

    // done_in stuck high across re-arm counts once
    a_if.done_in = 1'b1;
    repeat (50) @(negedge clk);
    check("a_stuck_cnt", 32'(a_if.evt_count), 32'd5);
    check("a_stuck_irq", 32'(a_if.irq), 32'd1);
    check("a_stuck_busy", 32'(a_if.busy), 32'd1);
    a_if.enable = 1'b0;
    @(negedge clk);
    check("a_dis_busy", 32'(a_if.busy), 32'd0);
    check("a_dis_restart", 32'(a_if.restart), 32'd0);
    check("a_dis_cnt", 32'(a_if.evt_count), 32'd5);
    check("a_dis_irq", 32'(a_if.irq), 32'd1);
    a_if.done_in = 1'b0;

    // AUTO_REARM=0 waits in HOLD for ack
    b_if.enable = 1'b1;
    repeat (3) @(negedge clk);
    check("b_armed_restart", 32'(b_if.restart), 32'd0);
    b_if.done_in = 1'b1;
    @(negedge clk);
    check("b_evt_irq", 32'(b_if.irq), 32'd1);
    check("b_evt_cnt", 32'(b_if.evt_count), 32'd1);
    b_if.done_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("b_hold_restart", 32'(b_if.restart), 32'd0);
    end
    b_if.done_in = 1'b1;
    @(negedge clk);
    b_if.done_in = 1'b0;
    @(negedge clk);
    check("b_hold_ignore_cnt", 32'(b_if.evt_count), 32'd1);
    check("b_hold_busy", 32'(b_if.busy), 32'd1);
    b_if.ack = 1'b1;
    @(negedge clk);
    check("b_ack_restart", 32'(b_if.restart), 32'd1);
    check("b_ack_irq", 32'(b_if.irq), 32'd0);
    b_if.ack = 1'b0;
    @(negedge clk);
    check("b_ack_restart_2", 32'(b_if.restart), 32'd1);
    @(negedge clk);
    check("b_ack_restart_end", 32'(b_if.restart), 32'd0);
    b_if.enable = 1'b0;

    // CNT_W=2 saturation and clear, RST_LEN=1
    c_if.enable = 1'b1;
    @(negedge clk);
    check("c_arm_restart", 32'(c_if.restart), 32'd1);
    @(negedge clk);
    check("c_arm_restart_end", 32'(c_if.restart), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      c_if.done_in = 1'b1;
      @(negedge clk);
      check("c_sat_cnt", 32'(c_if.evt_count), (k > 3) ? 32'd3 : 32'(k));
      check("c_sat_ovf", 32'(c_if.ovf), (k > 3) ? 32'd1 : 32'd0);
      c_if.done_in = 1'b0;
      @(negedge clk);
      check("c_sat_restart", 32'(c_if.restart), 32'd1);
      @(negedge clk);
    end
    c_if.clr_cnt = 1'b1;
    @(negedge clk);
    check("c_clr_cnt", 32'(c_if.evt_count), 32'd0);
    check("c_clr_ovf", 32'(c_if.ovf), 32'd0);
    c_if.clr_cnt = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      c_if.done_in = 1'b1;
      @(negedge clk);
      c_if.done_in = 1'b0;
      repeat (2) @(negedge clk);
    end
    check("c_pre_clr_cnt", 32'(c_if.evt_count), 32'd2);
    c_if.clr_cnt = 1'b1;
    c_if.done_in = 1'b1;
    @(negedge clk);
    check("c_clr_evt_cnt", 32'(c_if.evt_count), 32'd1);
    check("c_clr_evt_ovf", 32'(c_if.ovf), 32'd0);
    c_if.clr_cnt = 1'b0;
    c_if.done_in = 1'b0;

    // async reset in the middle of RESTART
    a_if.enable = 1'b1;
    @(negedge clk);
    check("a_pre_rst_restart", 32'(a_if.restart), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_restart", 32'(a_if.restart), 32'd0);
    check("mid_rst_irq", 32'(a_if.irq), 32'd0);
    check("mid_rst_cnt", 32'(a_if.evt_count), 32'd0);
    check("mid_rst_ovf", 32'(a_if.ovf), 32'd0);
    check("mid_rst_busy", 32'(a_if.busy), 32'd0);
    check("mid_rst_c_cnt", 32'(c_if.evt_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
